sprite_rom_arbiter: RTL

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM between NREQ requesters, with a ROM_LAT-deep response pipeline.
// Optional build macro ARB_PLAYER_PRIO_EN gives requester 0 (player) absolute priority.
module sprite_rom_arbiter #(
    parameter int NREQ    = 6,
    parameter int AW      = 16,
    parameter int ROM_LAT = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    output logic [NREQ-1:0]          gnt,
    output logic [AW-1:0]            rom_addr,
    output logic                     rom_rd,
    input  logic [4:0]               rom_data,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [4:0]               rsp_index
);

    logic [2:0]      ptr_q;
    logic [2:0]      ptr_d;
    logic            grant_s;
    logic [2:0]      win_s;
    logic            upd_ptr_s;
    logic [NREQ-1:0] gnt_s;
    logic [AW-1:0]   rom_addr_q;
    logic [AW-1:0]   rom_addr_d;
    logic [NREQ-1:0] pipe_q [ROM_LAT];
    logic [NREQ-1:0] last_in_s;
    logic [4:0]      rsp_index_q;
    logic [4:0]      rsp_index_d;

    // Winner selection, grant vector, pointer and ROM address next state
    always_comb begin
        grant_s   = 1'b0;
        win_s     = 3'd0;
        upd_ptr_s = 1'b0;
        gnt_s     = '0;
        // Walk the search order backwards so the first requester from ptr wins last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            win_s   = req[(int'(ptr_q) + i) % NREQ] ? 3'((int'(ptr_q) + i) % NREQ) : win_s;
            grant_s = grant_s | req[(int'(ptr_q) + i) % NREQ];
        end
`ifdef ARB_PLAYER_PRIO_EN
        win_s     = req[0] ? 3'd0 : win_s;
        grant_s   = grant_s & ~Reset;
        upd_ptr_s = grant_s & ~req[0];
`else
        grant_s   = grant_s & ~Reset;
        upd_ptr_s = grant_s;
`endif
        for (int i = 0; i < NREQ; i++) begin
            gnt_s[i] = grant_s && (win_s == 3'(i));
        end
        ptr_d       = upd_ptr_s ? ((win_s == 3'(NREQ - 1)) ? 3'd0 : win_s + 3'd1) : ptr_q;
        rom_addr_d  = grant_s ? req_addr[win_s] : rom_addr_q;
        rsp_index_d = (|last_in_s) ? rom_data : rsp_index_q;
    end

    // The last pipeline stage is fed straight from the grant when the ROM answers in one cycle.
    generate
        if (ROM_LAT == 1) begin : g_lat1
            assign last_in_s = gnt_s;
        end else begin : g_latn
            assign last_in_s = pipe_q[ROM_LAT-2];
        end
    endgenerate

    // Pointer and held ROM address registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q      <= 3'd0;
            rom_addr_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // Grant pipeline (one-hot id per stage) and response index register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int j = 0; j < ROM_LAT; j++) begin
                pipe_q[j] <= '0;
            end
            rsp_index_q <= 5'd0;
        end else begin
            pipe_q[0] <= gnt_s;
            for (int j = 1; j < ROM_LAT; j++) begin
                pipe_q[j] <= pipe_q[j-1];
            end
            rsp_index_q <= rsp_index_d;
        end
    end

    assign gnt       = gnt_s;
    assign rom_rd    = grant_s;
    assign rom_addr  = rom_addr_d;
    assign rsp_valid = pipe_q[ROM_LAT-1];
    assign rsp_index = rsp_index_q;

endmodule
